// File: rtl/taxi_axi_burst_master_if.sv
// AXI4 bus bundle shared by the burst master and bench slave models.
// Write-side and read-side modports let one instance carry either direction.
interface taxi_axi_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64,
  parameter int STRB_W = DATA_W / 8,
  parameter int ID_W   = 4
) ();
  logic [ID_W-1:0]   awid;
  logic [ADDR_W-1:0] awaddr;
  logic [7:0]        awlen;
  logic [2:0]        awsize;
  logic [1:0]        awburst;
  logic              awlock;
  logic [3:0]        awcache;
  logic [2:0]        awprot;
  logic [3:0]        awqos;
  logic [3:0]        awregion;
  logic              awvalid;
  logic              awready;
  logic [DATA_W-1:0] wdata;
  logic [STRB_W-1:0] wstrb;
  logic              wlast;
  logic              wvalid;
  logic              wready;
  logic [ID_W-1:0]   bid;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;
  logic [ID_W-1:0]   arid;
  logic [ADDR_W-1:0] araddr;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic              arlock;
  logic [3:0]        arcache;
  logic [2:0]        arprot;
  logic [3:0]        arqos;
  logic [3:0]        arregion;
  logic              arvalid;
  logic              arready;
  logic [ID_W-1:0]   rid;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rlast;
  logic              rvalid;
  logic              rready;

  modport wr_mst (
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awregion, awvalid,
    output wdata, wstrb, wlast, wvalid, bready,
    input  awready, wready, bid, bresp, bvalid
  );
  modport wr_slv (
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awregion, awvalid,
    input  wdata, wstrb, wlast, wvalid, bready,
    output awready, wready, bid, bresp, bvalid
  );
  modport rd_mst (
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arregion, arvalid,
    output rready,
    input  arready, rid, rdata, rresp, rlast, rvalid
  );
  modport rd_slv (
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arregion, arvalid,
    input  rready,
    output arready, rid, rdata, rresp, rlast, rvalid
  );
endinterface

// File: rtl/taxi_axi_burst_master.sv
// Command-driven AXI4 INCR burst master: independent write and read engines,
// each rejecting bursts that would cross a 4 KiB boundary.
module taxi_axi_burst_master #(
  parameter int         AXI_ID = 0,
  parameter logic [3:0] CACHE  = 4'b0011,
  parameter int         ADDR_W = 32,
  parameter int         DATA_W = 64,
  parameter int         ID_W   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  taxi_axi_if.wr_mst        m_axi_wr,
  taxi_axi_if.rd_mst        m_axi_rd,
  input  logic [ADDR_W-1:0] wr_cmd_addr,
  input  logic [7:0]        wr_cmd_len,
  input  logic              wr_cmd_valid,
  output logic              wr_cmd_ready,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_data_valid,
  output logic              wr_data_ready,
  output logic              wr_done,
  output logic              wr_err,
  input  logic [ADDR_W-1:0] rd_cmd_addr,
  input  logic [7:0]        rd_cmd_len,
  input  logic              rd_cmd_valid,
  output logic              rd_cmd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_data_last,
  output logic              rd_data_err,
  output logic              rd_data_valid,
  input  logic              rd_data_ready,
  output logic              rd_done,
  output logic              rd_err
);
  localparam int         STRB_W = DATA_W / 8;
  localparam logic [2:0] AXSIZE = 3'($clog2(STRB_W));

  if (m_axi_wr.DATA_W != DATA_W || m_axi_rd.DATA_W != DATA_W) begin : g_width_check
    $fatal(1, "taxi_axi_burst_master: DATA_W differs between m_axi_wr, m_axi_rd and the module");
  end

  typedef enum logic [1:0] {WR_IDLE, WR_ADDR, WR_DATA, WR_RESP} wr_state_t;
  typedef enum logic [1:0] {RD_IDLE, RD_ADDR, RD_DATA} rd_state_t;

  wr_state_t         r_wr_state;
  logic              r_wr_cmd_ready, r_awvalid, r_bready, r_wr_done, r_wr_err;
  logic [ADDR_W-1:0] r_awaddr;
  logic [7:0]        r_awlen, r_wr_cnt;
  rd_state_t         r_rd_state;
  logic              r_rd_cmd_ready, r_arvalid, r_rd_done, r_rd_err, r_rd_err_acc;
  logic [ADDR_W-1:0] r_araddr;
  logic [7:0]        r_arlen;

  // Span is the byte offset just past the burst within its 4 KiB page.
  logic [23:0] w_wr_span, w_rd_span;
  logic        w_wr_bad, w_rd_bad, w_w_hs, w_r_hs, w_r_beat_err;
  assign w_wr_span = 24'(wr_cmd_addr[11:0]) + (24'(wr_cmd_len) + 24'd1) * 24'(STRB_W);
  assign w_rd_span = 24'(rd_cmd_addr[11:0]) + (24'(rd_cmd_len) + 24'd1) * 24'(STRB_W);
  assign w_wr_bad  = w_wr_span > 24'd4096;
  assign w_rd_bad  = w_rd_span > 24'd4096;
  assign w_w_hs    = m_axi_wr.wvalid && m_axi_wr.wready;
  assign w_r_hs    = m_axi_rd.rvalid && m_axi_rd.rready;
  assign w_r_beat_err = (m_axi_rd.rresp != 2'b00) || (m_axi_rd.rid != ID_W'(AXI_ID));

  assign m_axi_wr.awid     = ID_W'(AXI_ID);
  assign m_axi_wr.awaddr   = r_awaddr;
  assign m_axi_wr.awlen    = r_awlen;
  assign m_axi_wr.awsize   = AXSIZE;
  assign m_axi_wr.awburst  = 2'b01;
  assign m_axi_wr.awlock   = 1'b0;
  assign m_axi_wr.awcache  = CACHE;
  assign m_axi_wr.awprot   = 3'b000;
  assign m_axi_wr.awqos    = 4'b0000;
  assign m_axi_wr.awregion = 4'b0000;
  assign m_axi_wr.awvalid  = r_awvalid;
  assign m_axi_wr.wdata    = wr_data;
  assign m_axi_wr.wstrb    = '1;
  assign m_axi_wr.wlast    = (r_wr_cnt == 8'd0);
  assign m_axi_wr.wvalid   = (r_wr_state == WR_DATA) && wr_data_valid;
  assign m_axi_wr.bready   = r_bready;
  assign wr_data_ready     = (r_wr_state == WR_DATA) && m_axi_wr.wready;
  assign wr_cmd_ready      = r_wr_cmd_ready;
  assign wr_done           = r_wr_done;
  assign wr_err            = r_wr_err;

  assign m_axi_rd.arid     = ID_W'(AXI_ID);
  assign m_axi_rd.araddr   = r_araddr;
  assign m_axi_rd.arlen    = r_arlen;
  assign m_axi_rd.arsize   = AXSIZE;
  assign m_axi_rd.arburst  = 2'b01;
  assign m_axi_rd.arlock   = 1'b0;
  assign m_axi_rd.arcache  = CACHE;
  assign m_axi_rd.arprot   = 3'b000;
  assign m_axi_rd.arqos    = 4'b0000;
  assign m_axi_rd.arregion = 4'b0000;
  assign m_axi_rd.arvalid  = r_arvalid;
  assign m_axi_rd.rready   = (r_rd_state == RD_DATA) && rd_data_ready;
  assign rd_data           = m_axi_rd.rdata;
  assign rd_data_last      = m_axi_rd.rlast;
  assign rd_data_err       = (m_axi_rd.rresp != 2'b00);
  assign rd_data_valid     = (r_rd_state == RD_DATA) && m_axi_rd.rvalid;
  assign rd_cmd_ready      = r_rd_cmd_ready;
  assign rd_done           = r_rd_done;
  assign rd_err            = r_rd_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_state     <= WR_IDLE;
      r_wr_cmd_ready <= 1'b0;
      r_awvalid      <= 1'b0;
      r_bready       <= 1'b0;
      r_wr_done      <= 1'b0;
      r_wr_err       <= 1'b0;
      r_awaddr       <= '0;
      r_awlen        <= 8'd0;
      r_wr_cnt       <= 8'd0;
    end else begin
      r_wr_done <= 1'b0;
      r_wr_err  <= 1'b0;
      case (r_wr_state)
        WR_IDLE: begin
          r_wr_cmd_ready <= 1'b1;
          if (wr_cmd_valid && r_wr_cmd_ready) begin
            r_wr_cmd_ready <= 1'b0;
            if (w_wr_bad) begin
              r_wr_done <= 1'b1;
              r_wr_err  <= 1'b1;
            end else begin
              r_awaddr   <= wr_cmd_addr;
              r_awlen    <= wr_cmd_len;
              r_wr_cnt   <= wr_cmd_len;
              r_awvalid  <= 1'b1;
              r_wr_state <= WR_ADDR;
            end
          end
        end
        WR_ADDR: begin
          if (m_axi_wr.awready) begin
            r_awvalid  <= 1'b0;
            r_wr_state <= WR_DATA;
          end
        end
        WR_DATA: begin
          if (w_w_hs) begin
            if (r_wr_cnt == 8'd0) begin
              r_bready   <= 1'b1;
              r_wr_state <= WR_RESP;
            end else begin
              r_wr_cnt <= r_wr_cnt - 8'd1;
            end
          end
        end
        WR_RESP: begin
          if (m_axi_wr.bvalid) begin
            r_bready       <= 1'b0;
            r_wr_done      <= 1'b1;
            r_wr_err       <= (m_axi_wr.bresp != 2'b00);
            r_wr_cmd_ready <= 1'b1;
            r_wr_state     <= WR_IDLE;
          end
        end
        default: r_wr_state <= WR_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_state     <= RD_IDLE;
      r_rd_cmd_ready <= 1'b0;
      r_arvalid      <= 1'b0;
      r_rd_done      <= 1'b0;
      r_rd_err       <= 1'b0;
      r_rd_err_acc   <= 1'b0;
      r_araddr       <= '0;
      r_arlen        <= 8'd0;
    end else begin
      r_rd_done <= 1'b0;
      r_rd_err  <= 1'b0;
      case (r_rd_state)
        RD_IDLE: begin
          r_rd_cmd_ready <= 1'b1;
          if (rd_cmd_valid && r_rd_cmd_ready) begin
            r_rd_cmd_ready <= 1'b0;
            r_rd_err_acc   <= 1'b0;
            if (w_rd_bad) begin
              r_rd_done <= 1'b1;
              r_rd_err  <= 1'b1;
            end else begin
              r_araddr   <= rd_cmd_addr;
              r_arlen    <= rd_cmd_len;
              r_arvalid  <= 1'b1;
              r_rd_state <= RD_ADDR;
            end
          end
        end
        RD_ADDR: begin
          if (m_axi_rd.arready) begin
            r_arvalid  <= 1'b0;
            r_rd_state <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (w_r_hs) begin
            // Error flags from every beat, including the last, fold into rd_err.
            r_rd_err_acc <= r_rd_err_acc | w_r_beat_err;
            if (m_axi_rd.rlast) begin
              r_rd_done      <= 1'b1;
              r_rd_err       <= r_rd_err_acc | w_r_beat_err;
              r_rd_cmd_ready <= 1'b1;
              r_rd_state     <= RD_IDLE;
            end
          end
        end
        default: r_rd_state <= RD_IDLE;
      endcase
    end
  end
endmodule

// File: doc/taxi_axi_burst_master.md
TAXI_AXI_BURST_MASTER -- requirements
Module: taxi_axi_burst_master

Interface
REQ-001 Parameter AXI_ID, default 0: ID value driven on awid and arid.
REQ-002 Parameter CACHE, default 4'b0011: value driven on awcache and arcache.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst_n  input  1  asynchronous assert, active-low reset; release is synchronous to clk.
REQ-005 wr_cmd_addr  input  ADDR_W (m_axi_wr.ADDR_W)  write burst start byte address, STRB_W-aligned.
REQ-006 wr_cmd_len  input  8  write beats minus one.
REQ-007 wr_cmd_valid / wr_cmd_ready  input / output  1  write command handshake.
REQ-008 wr_data  input  DATA_W  write beat data; wr_data_valid / wr_data_ready  input / output  1  write data handshake.
REQ-009 wr_done  output  1  one-cycle pulse at write completion; wr_err  output  1  valid with wr_done, set for non-OKAY bresp or rejected command.
REQ-010 rd_cmd_addr  input  ADDR_W; rd_cmd_len  input  8; rd_cmd_valid / rd_cmd_ready  input / output  1  read command, same semantics as write.
REQ-011 rd_data  output  DATA_W; rd_data_last  output  1; rd_data_err  output  1 (rresp != OKAY); rd_data_valid / rd_data_ready  output / input  1  read data stream.
REQ-012 rd_done  output  1  one-cycle pulse after the last read beat transfers or on a rejected read command; rd_err  output  1  valid with rd_done.
REQ-013 m_axi_wr  taxi_axi_if.wr_mst  AXI4 write master; m_axi_rd  taxi_axi_if.rd_mst  AXI4 read master; DATA_W must match on both, else $fatal.

Function
REQ-014 Write FSM states: IDLE, ADDR, DATA, RESP; read FSM states: IDLE, ADDR, DATA; the two FSMs are fully independent and may run concurrently.
REQ-015 wr_cmd_ready / rd_cmd_ready registered, high only in IDLE; the command is accepted on the valid&&ready cycle N.
REQ-016 Accepted command whose span addr[11:0] + (len+1)*STRB_W exceeds 4096: no AXI activity; done=1 and err=1 on cycle N+1; FSM returns to IDLE, and ready is high again on N+2.
REQ-017 Otherwise, the FSM enters ADDR and awvalid/arvalid is registered high from cycle N+1 until the AW/AR handshake.
REQ-018 AW/AR fields: addr = cmd addr, len = cmd len, size = $clog2(STRB_W), burst = INCR, id = AXI_ID, lock=0, cache=CACHE, prot=0, qos=0, region=0.
REQ-019 Write DATA: combinational pass-through, wvalid = wr_data_valid, wr_data_ready = wready, wdata = wr_data, wstrb all ones; 8-bit beat counter loaded with len.
REQ-020 wlast high when the beat counter is 0; the counter decrements on each W handshake; the W handshake with wlast enters RESP.
REQ-021 W beats are not issued before the AW handshake completes; wvalid and wr_data_ready are 0 outside DATA.
REQ-022 RESP: bready=1; on the B handshake, wr_done pulses next cycle, wr_err = (bresp != 2'b00), and the FSM returns to IDLE.
REQ-023 Read DATA: pass-through, rd_data_valid = rvalid, rready = rd_data_ready, rd_data/rd_data_last/rd_data_err from rdata/rlast/rresp; rready=0 outside DATA.
REQ-024 An R handshake with rlast returns to IDLE; rd_done pulses next cycle; rd_err = OR of all rd_data_err in the burst.
REQ-025 An R beat with rid != AXI_ID is forwarded and flags rd_err.
REQ-026 len=0 (single beat): wlast and rlast behave on the first beat; address sequencing is unaffected.
REQ-027 AXI valid signals never drop before their handshake, and payload fields are stable while valid is high.

Reset
REQ-028 While rst_n=0: all FSMs in IDLE; awvalid, arvalid, bready, wr_cmd_ready, rd_cmd_ready, wr_done, rd_done, wr_err, rd_err, and beat counters are 0.
REQ-029 Command ready rises on the first clk edge after rst_n release.
REQ-030 Reset mid-burst aborts immediately with no completion pulse; outstanding AXI transactions are the system's responsibility.

Verification
REQ-031 Write addr 0x100, len 3, four data words, RAM slave -> one AW (awlen=3, awburst=INCR), four W with wlast on the 4th, wr_done=1, wr_err=0; readback matches.
REQ-032 Read addr 0x100, len 3, with rd_data_ready toggling every cycle -> four beats in order, rd_data_last on the 4th only, rd_done once, rd_err=0.
REQ-033 Write addr 0xFF8, len 1, STRB_W=8 -> awvalid never asserted; wr_done=1 and wr_err=1 one cycle after accept.
REQ-034 Slave returns bresp=2'b10 -> wr_done=1, wr_err=1; next command accepted normally.
REQ-035 Concurrent write and read commands accepted in the same cycle -> both complete with correct data and one done pulse each.
REQ-036 rst_n pulled low during the 2nd of 4 write beats -> all outputs 0 within the reset, no wr_done; a fresh command after release completes normally.
